// File: rtl/style_frame_scheduler_if.sv
// Style scheduler bus: key/frame/line inputs from the sync and key logic,
// committed style code, pending flag, mask and frame count to the style mux.
interface style_frame_scheduler_if;
    logic       iKey_next;
    logic       iKey_prev;
    logic       iAuto_en;
    logic       iFrame_start;
    logic       iLine_start;
    logic [2:0] oCtrl;
    logic       oPending;
    logic       oMask;
    logic [7:0] oFrame_cnt;

    modport master (
        output iKey_next, iKey_prev, iAuto_en, iFrame_start, iLine_start,
        input  oCtrl, oPending, oMask, oFrame_cnt
    );

    modport slave (
        input  iKey_next, iKey_prev, iAuto_en, iFrame_start, iLine_start,
        output oCtrl, oPending, oMask, oFrame_cnt
    );
endinterface

// File: rtl/style_frame_scheduler.sv
// Frame-synchronous style selector for the per-pixel style mux.
// Keys move a pending request; the request is committed only on a frame
// start so a frame never shows mixed styles. After committing the edge
// style, the output is masked until the 3x3 line buffers have refilled.
// Optional auto-cycle is built only when STYLE_SCHED_AUTO_EN is defined;
// otherwise iAuto_en is ignored and no auto counter exists.
//
// state  | meaning
// S_RUN  | normal output, oMask low
// S_WARM | edge style just committed, oMask high until WARMUP_LINES lines seen
module style_frame_scheduler #(
    parameter int NUM_STYLES   = 4,
    parameter int AUTO_FRAMES  = 60,
    parameter int WARMUP_LINES = 2,
    parameter int EDGE_CODE    = 2
) (
    input  logic iCLK,
    input  logic iRST,
    style_frame_scheduler_if.slave bus
);
    localparam logic [2:0] LAST_CODE = 3'(NUM_STYLES - 1);
    localparam logic [2:0] EDGE      = 3'(EDGE_CODE);
    localparam int         LINE_W    = $clog2(WARMUP_LINES + 1);
    localparam logic [LINE_W-1:0] LINE_LOAD = LINE_W'(WARMUP_LINES);
    localparam logic [LINE_W-1:0] LINE_ONE  = LINE_W'(1);

    typedef enum logic {S_RUN, S_WARM} state_t;

    state_t            state;
    logic [2:0]        req;
    logic [2:0]        ctrl;
    logic              pending;
    logic              mask;
    logic [7:0]        frame_cnt;
    logic [LINE_W-1:0] line_cnt;

    logic       key_any;
    logic [2:0] req_keyed;
    logic       manual_commit;
    logic       auto_fire;
    logic       commit;
    logic [2:0] new_code;

    function automatic logic [2:0] inc_code(input logic [2:0] c);
        return (c == LAST_CODE) ? 3'd0 : c + 3'd1;
    endfunction

    function automatic logic [2:0] dec_code(input logic [2:0] c);
        return (c == 3'd0) ? LAST_CODE : c - 3'd1;
    endfunction

    assign key_any = bus.iKey_next | bus.iKey_prev;

    // Key decode and commit decision; the commit always uses the request
    // as it stood before any key arriving in the same cycle.
    always_comb begin
        req_keyed = req;
        if (bus.iKey_next && !bus.iKey_prev) begin
            req_keyed = inc_code(req);
        end else if (bus.iKey_prev && !bus.iKey_next) begin
            req_keyed = dec_code(req);
        end
        manual_commit = bus.iFrame_start && (req != ctrl);
        commit        = manual_commit || auto_fire;
        new_code      = manual_commit ? req : inc_code(ctrl);
    end

`ifdef STYLE_SCHED_AUTO_EN
    localparam int AUTO_W = $clog2(AUTO_FRAMES);
    localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_FRAMES - 1);
    localparam logic [AUTO_W-1:0] AUTO_ONE  = AUTO_W'(1);

    logic [AUTO_W-1:0] auto_cnt;

    // A key in the firing frame wins: the manual choice restarts the dwell.
    assign auto_fire = bus.iAuto_en && bus.iFrame_start && !manual_commit
                       && !key_any && (auto_cnt == AUTO_LAST);

    // Dwell counter: frames since the last commit or key while auto is on.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            auto_cnt <= '0;
        end else if (!bus.iAuto_en || key_any || commit) begin
            auto_cnt <= '0;
        end else if (bus.iFrame_start) begin
            auto_cnt <= auto_cnt + AUTO_ONE;
        end
    end
`else
    logic auto_unused;
    assign auto_unused = bus.iAuto_en;
    assign auto_fire   = 1'b0;
`endif

    // Request, committed code, pending flag and frame counter.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            req       <= 3'd0;
            ctrl      <= 3'd0;
            pending   <= 1'b0;
            frame_cnt <= 8'd0;
        end else begin
            req     <= auto_fire ? inc_code(ctrl) : req_keyed;
            pending <= (req != ctrl);
            if (commit) begin
                ctrl <= new_code;
            end
            if (bus.iFrame_start) begin
                if (commit) begin
                    frame_cnt <= 8'd0;
                end else if (frame_cnt != 8'hFF) begin
                    frame_cnt <= frame_cnt + 8'd1;
                end
            end
        end
    end

    // Warmup FSM: mask rises with the edge-style commit, falls after the lines refill.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state    <= S_RUN;
            mask     <= 1'b0;
            line_cnt <= '0;
        end else if (commit) begin
            if (new_code == EDGE) begin
                state    <= S_WARM;
                mask     <= 1'b1;
                line_cnt <= LINE_LOAD;
            end else begin
                state <= S_RUN;
                mask  <= 1'b0;
            end
        end else begin
            case (state)
                S_RUN: begin
                    mask <= 1'b0;
                end
                S_WARM: begin
                    if (bus.iLine_start) begin
                        if (line_cnt <= LINE_ONE) begin
                            state    <= S_RUN;
                            mask     <= 1'b0;
                            line_cnt <= '0;
                        end else begin
                            line_cnt <= line_cnt - LINE_ONE;
                        end
                    end
                end
                default: begin
                    state <= S_RUN;
                    mask  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.oCtrl      = ctrl;
    assign bus.oPending   = pending;
    assign bus.oMask      = mask;
    assign bus.oFrame_cnt = frame_cnt;
endmodule

// File: tb/tb_style_frame_scheduler.sv
// Directed bench for style_frame_scheduler (AUTO_FRAMES=4, WARMUP_LINES=2).
// Stimulus pushes the expected outputs for the cycle after each applied
// input vector; a separate monitor pops and compares them.
// Expectations for auto-cycle follow STYLE_SCHED_AUTO_EN.
module tb_style_frame_scheduler;
`ifdef STYLE_SCHED_AUTO_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic iCLK = 1'b0;
    logic iRST = 1'b1;
    int   cyc  = 0;
    int   checks = 0;
    int   errors = 0;

    style_frame_scheduler_if bus();

    style_frame_scheduler #(
        .NUM_STYLES  (4),
        .AUTO_FRAMES (4),
        .WARMUP_LINES(2),
        .EDGE_CODE   (2)
    ) dut (
        .iCLK(iCLK),
        .iRST(iRST),
        .bus (bus)
    );

    always #5 iCLK = ~iCLK;
    always @(posedge iCLK) cyc <= cyc + 1;

    typedef struct {
        int         due;
        string      name;
        logic [2:0] c;
        logic       p;
        logic       m;
        logic [7:0] f;
    } exp_t;

    exp_t q[$];

    // Apply one cycle of inputs and queue the outputs expected after that edge.
    task automatic step(input string name, input bit r, input bit nx, input bit pv,
                        input bit fs, input bit ls, input bit ae,
                        input int c, input int p, input int m, input int f);
        exp_t e;
        @(posedge iCLK);
        #1;
        iRST             = r;
        bus.iKey_next    = nx;
        bus.iKey_prev    = pv;
        bus.iFrame_start = fs;
        bus.iLine_start  = ls;
        bus.iAuto_en     = ae;
        e.due  = cyc + 1;
        e.name = name;
        e.c    = 3'(c);
        e.p    = 1'(p);
        e.m    = 1'(m);
        e.f    = 8'(f);
        q.push_back(e);
    endtask

    // Monitor: compare every queued expectation that falls due this cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge iCLK);
            #3;
            while (q.size() > 0 && q[0].due <= cyc) begin
                e = q.pop_front();
                checks++;
                if (e.due < cyc) begin
                    errors++;
                    $display("FAIL %s: stale expectation due %0d seen at %0d", e.name, e.due, cyc);
                end else if ({bus.oCtrl, bus.oPending, bus.oMask, bus.oFrame_cnt}
                             !== {e.c, e.p, e.m, e.f}) begin
                    errors++;
                    $display("FAIL %s: got ctrl=%0d pend=%0d mask=%0d fcnt=%0d, expected ctrl=%0d pend=%0d mask=%0d fcnt=%0d",
                             e.name, bus.oCtrl, bus.oPending, bus.oMask, bus.oFrame_cnt,
                             e.c, e.p, e.m, e.f);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached with %0d expectations queued", q.size());
        $fatal(1, "watchdog");
    end

    // Auto run expectations for frames 1..9 after reset with auto enabled.
    int run_c[9] = '{0, 0, 0, 1, 1, 1, 1, 2, 2};
    int run_f[9] = '{1, 2, 3, 0, 1, 2, 3, 0, 1};
    int run_m[9] = '{0, 0, 0, 0, 0, 0, 0, 1, 1};

    // Directed stimulus.
    initial begin
        bus.iKey_next    = 1'b0;
        bus.iKey_prev    = 1'b0;
        bus.iFrame_start = 1'b0;
        bus.iLine_start  = 1'b0;
        bus.iAuto_en     = 1'b0;

        //    name         r  nx pv fs ls ae   c  p  m  f
        step("rst0",       1, 0, 0, 0, 0, 0,   0, 0, 0, 0);
        step("rst1",       1, 0, 0, 0, 0, 0,   0, 0, 0, 0);

        // three next keys, then commit to 3
        step("k1",         0, 1, 0, 0, 0, 0,   0, 0, 0, 0);
        step("k2",         0, 1, 0, 0, 0, 0,   0, 1, 0, 0);
        step("k3",         0, 1, 0, 0, 0, 0,   0, 1, 0, 0);
        step("commit3",    0, 0, 0, 1, 0, 0,   3, 1, 0, 0);
        step("settle3",    0, 0, 0, 0, 0, 0,   3, 0, 0, 0);

        // wrap up and down
        step("next_wrap",  0, 1, 0, 0, 0, 0,   3, 0, 0, 0);
        step("commit0",    0, 0, 0, 1, 0, 0,   0, 1, 0, 0);
        step("settle0",    0, 0, 0, 0, 0, 0,   0, 0, 0, 0);
        step("prev_wrap",  0, 0, 1, 0, 0, 0,   0, 0, 0, 0);
        step("commit3b",   0, 0, 0, 1, 0, 0,   3, 1, 0, 0);
        step("settle3b",   0, 0, 0, 0, 0, 0,   3, 0, 0, 0);

        // to style 1, then edge style with warmup
        step("to1_a",      0, 1, 0, 0, 0, 0,   3, 0, 0, 0);
        step("to1_b",      0, 1, 0, 0, 0, 0,   3, 1, 0, 0);
        step("commit1",    0, 0, 0, 1, 0, 0,   1, 1, 0, 0);
        step("settle1",    0, 0, 0, 0, 0, 0,   1, 0, 0, 0);
        step("to_edge",    0, 1, 0, 0, 0, 0,   1, 0, 0, 0);
        step("commit_edge",0, 0, 0, 1, 0, 0,   2, 1, 1, 0);
        step("warm_idle",  0, 0, 0, 0, 0, 0,   2, 0, 1, 0);
        step("warm_line1", 0, 0, 0, 0, 1, 0,   2, 0, 1, 0);
        step("warm_gap",   0, 0, 0, 0, 0, 0,   2, 0, 1, 0);
        step("warm_line2", 0, 0, 0, 0, 1, 0,   2, 0, 0, 0);
        step("run_line3",  0, 0, 0, 0, 1, 0,   2, 0, 0, 0);

        // line start on the commit cycle is not counted; frame without commit keeps warm
        step("back1",      0, 0, 1, 0, 0, 0,   2, 0, 0, 0);
        step("commit1b",   0, 0, 0, 1, 0, 0,   1, 1, 0, 0);
        step("to_edge2",   0, 1, 0, 0, 0, 0,   1, 0, 0, 0);
        step("commit_line",0, 0, 0, 1, 1, 0,   2, 1, 1, 0);
        step("wl_a",       0, 0, 0, 0, 1, 0,   2, 0, 1, 0);
        step("warm_frame", 0, 0, 0, 1, 0, 0,   2, 0, 1, 1);
        step("wl_b",       0, 0, 0, 0, 1, 0,   2, 0, 0, 1);

        // leaving warmup by committing a non-edge style
        step("back1c",     0, 0, 1, 0, 0, 0,   2, 0, 0, 1);
        step("commit1c",   0, 0, 0, 1, 0, 0,   1, 1, 0, 0);
        step("to_edge3",   0, 1, 0, 0, 0, 0,   1, 0, 0, 0);
        step("commit_e3",  0, 0, 0, 1, 0, 0,   2, 1, 1, 0);
        step("req3_warm",  0, 1, 0, 0, 0, 0,   2, 0, 1, 0);
        step("exit_warm",  0, 0, 0, 1, 0, 0,   3, 1, 0, 0);
        step("settle_ex",  0, 0, 0, 0, 0, 0,   3, 0, 0, 0);

        // both keys together, frame counting, key on frame start
        step("rst2",       1, 0, 0, 0, 0, 0,   0, 0, 0, 0);
        step("both_keys",  0, 1, 1, 0, 0, 0,   0, 0, 0, 0);
        step("fc1",        0, 0, 0, 1, 0, 0,   0, 0, 0, 1);
        step("fc2",        0, 0, 0, 1, 0, 0,   0, 0, 0, 2);
        step("key_on_fs",  0, 1, 0, 1, 0, 0,   0, 0, 0, 3);
        step("pend_late",  0, 0, 0, 0, 0, 0,   0, 1, 0, 3);
        step("commit_nf",  0, 0, 0, 1, 0, 0,   1, 1, 0, 0);
        step("settle_nf",  0, 0, 0, 0, 0, 0,   1, 0, 0, 0);

        // frame counter saturation
        for (int k = 1; k <= 260; k++) begin
            step("fcnt_sat",  0, 0, 0, 1, 0, 0,   1, 0, 0, (k > 255) ? 255 : k);
        end

        // reset while warming up discards everything including the request
        step("to_edge4",   0, 1, 0, 0, 0, 0,   1, 0, 0, 255);
        step("commit_e4",  0, 0, 0, 1, 0, 0,   2, 1, 1, 0);
        step("warm_f",     0, 0, 0, 1, 0, 0,   2, 0, 1, 1);
        step("rst_warm",   1, 0, 0, 0, 0, 0,   0, 0, 0, 0);
        step("post_rst",   0, 0, 0, 0, 0, 0,   0, 0, 0, 0);
        step("post_rst_f", 0, 0, 0, 1, 0, 0,   0, 0, 0, 1);

        // auto-cycle, nine frames
        step("rst_auto",   1, 0, 0, 0, 0, 1,   0, 0, 0, 0);
        for (int i = 0; i < 9; i++) begin
            if (AUTO) step("auto_run", 0, 0, 0, 1, 0, 1, run_c[i], 0, run_m[i], run_f[i]);
            else      step("auto_run", 0, 0, 0, 1, 0, 1, 0, 0, 0, i + 1);
        end

        // auto-cycle with a key after the 5th frame and an enable drop
        step("rst_auto2",  1, 0, 0, 0, 0, 1,   0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            if (AUTO) step("auto2_run", 0, 0, 0, 1, 0, 1, run_c[i], 0, run_m[i], run_f[i]);
            else      step("auto2_run", 0, 0, 0, 1, 0, 1, 0, 0, 0, i + 1);
        end
        step("a2_key",  0, 1, 0, 0, 0, 1, AUTO ? 1 : 0, 0, 0, AUTO ? 1 : 5);
        step("a2_idle", 0, 0, 0, 0, 0, 1, AUTO ? 1 : 0, 1, 0, AUTO ? 1 : 5);
        step("a2_f6",   0, 0, 0, 1, 0, 1, AUTO ? 2 : 1, 1, AUTO ? 1 : 0, 0);
        step("a2_f7",   0, 0, 0, 1, 0, 1, AUTO ? 2 : 1, 0, AUTO ? 1 : 0, 1);
        step("a2_f8",   0, 0, 0, 1, 0, 1, AUTO ? 2 : 1, 0, AUTO ? 1 : 0, 2);
        step("a2_f9",   0, 0, 0, 1, 0, 1, AUTO ? 2 : 1, 0, AUTO ? 1 : 0, 3);
        step("a2_f10",  0, 0, 0, 1, 0, 1, AUTO ? 3 : 1, 0, 0, AUTO ? 0 : 4);
        step("a2_f11",  0, 0, 0, 1, 0, 1, AUTO ? 3 : 1, 0, 0, AUTO ? 1 : 5);
        step("a2_f12",  0, 0, 0, 1, 0, 1, AUTO ? 3 : 1, 0, 0, AUTO ? 2 : 6);
        step("a2_off",  0, 0, 0, 0, 0, 0, AUTO ? 3 : 1, 0, 0, AUTO ? 2 : 6);
        step("a2_on",   0, 0, 0, 0, 0, 1, AUTO ? 3 : 1, 0, 0, AUTO ? 2 : 6);
        step("a2_f13",  0, 0, 0, 1, 0, 1, AUTO ? 3 : 1, 0, 0, AUTO ? 3 : 7);
        step("a2_f14",  0, 0, 0, 1, 0, 1, AUTO ? 3 : 1, 0, 0, AUTO ? 4 : 8);
        step("a2_f15",  0, 0, 0, 1, 0, 1, AUTO ? 3 : 1, 0, 0, AUTO ? 5 : 9);
        step("a2_f16",  0, 0, 0, 1, 0, 1, AUTO ? 0 : 1, 0, 0, AUTO ? 0 : 10);
        step("a2_tail", 0, 0, 0, 0, 0, 0, AUTO ? 0 : 1, 0, 0, AUTO ? 0 : 10);

        repeat (3) @(posedge iCLK);
        #4;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
